// File: rtl/gpio_team_mux.sv
// Wishbone-programmable GPIO / chip-select arbiter: routes one team design to the pads,
// inserting an all-inputs holdoff on every switch. Optional lock: GPIO_TEAM_MUX_LOCK_EN.
module gpio_team_mux #(
    parameter int          NUM_TEAMS = 4,
    parameter int          NUM_PINS  = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          HOLDOFF   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          nrst,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_dat_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_out,
    input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_oeb,
    output logic [NUM_PINS-1:0]           gpio_out,
    output logic [NUM_PINS-1:0]           gpio_oeb,
    output logic [NUM_TEAMS-1:0]          designs_ncs,
    output logic                          busy
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [1:0] REG_ACTIVE  = 2'd0;
    localparam logic [1:0] REG_MASK_LO = 2'd1;
    localparam logic [1:0] REG_MASK_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int                CNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [7:0]        MAX_TEAM = 8'(NUM_TEAMS);

    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           active_q, active_d;
    logic [7:0]           pending_q, pending_d;
    logic [NUM_PINS-1:0]  mask_q, mask_d;
    logic                 err_q, err_d;
    logic                 lock_on;

    logic                 req, accept, wr, rd;
    logic [1:0]           reg_sel;
    logic [7:0]           wr_team;
    logic [31:0]          lane_m;
    logic [63:0]          mask_wide, mask_nxt;
    logic [31:0]          rdata;
    logic                 start_sw;
    logic                 run_sel;
    logic [NUM_PINS-1:0]  team_out, team_oeb;
    logic                 unused_sink;

    always_comb begin
        req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        // A request is only taken when no ack is outstanding, so acks never abut.
        accept    = req & ~ack_q;
        wr        = accept & wbs_we_i;
        rd        = accept & ~wbs_we_i;
        reg_sel   = wbs_adr_i[3:2];
        wr_team   = wbs_dat_i[7:0];
        lane_m    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
        mask_wide = 64'(mask_q);
    end

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_ACTIVE:  rdata = {24'h0, active_q};
            REG_MASK_LO: rdata = mask_wide[31:0];
            REG_MASK_HI: rdata = mask_wide[63:32];
            default:     rdata = {16'h0, pending_q, 5'h0, lock_on, err_q, (state_q == ST_DRAIN)};
        endcase
    end

    always_comb begin
        ack_d     = accept;
        dat_d     = rd ? rdata : 32'h0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;
        mask_nxt  = mask_wide;
        start_sw  = 1'b0;

        if (wr) begin
            case (reg_sel)
                REG_ACTIVE: begin
                    if (lock_on) begin
                        err_d = 1'b1;
                    end else if (wbs_sel_i[0]) begin
                        if (wr_team > MAX_TEAM) begin
                            err_d = 1'b1;
                        end else if (!(wr_team == active_q && state_q == ST_RUN)) begin
                            start_sw  = 1'b1;
                            pending_d = wr_team;
                        end
                    end
                end
                REG_MASK_LO: begin
                    if (lock_on) err_d = 1'b1;
                    else mask_nxt[31:0] = (mask_wide[31:0] & ~lane_m) | (wbs_dat_i & lane_m);
                end
                REG_MASK_HI: begin
                    if (lock_on) err_d = 1'b1;
                    else mask_nxt[63:32] = (mask_wide[63:32] & ~lane_m) | (wbs_dat_i & lane_m);
                end
                default: begin
                    if (wbs_sel_i[0] && wbs_dat_i[1]) err_d = 1'b0;
                end
            endcase
        end

        // A fresh switch request always wins over a commit due in the same cycle.
        if (start_sw) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
        end else if (state_q == ST_DRAIN) begin
            if (cnt_q == '0) begin
                active_d = pending_q;
                state_d  = ST_RUN;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        mask_d = mask_nxt[NUM_PINS-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge nrst) begin
        if (!nrst) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            active_q  <= 8'h0;
            pending_q <= 8'h0;
            mask_q    <= '1;
            err_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
        end
    end

`ifdef GPIO_TEAM_MUX_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (wr && reg_sel == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[2]) lock_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge nrst) begin
        if (!nrst) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end

    assign lock_on = lock_q;
`else
    assign lock_on = 1'b0;
`endif

    // Pads are routed only in RUN with a real team selected; otherwise all inputs.
    always_comb begin
        run_sel  = (state_q == ST_RUN) && (active_q != 8'h0);
        team_out = '0;
        team_oeb = '1;
        for (int t = 0; t < NUM_TEAMS; t++) begin
            if (active_q == 8'(t + 1)) begin
                team_out = designs_gpio_out[t*NUM_PINS +: NUM_PINS];
                team_oeb = designs_gpio_oeb[t*NUM_PINS +: NUM_PINS];
            end
        end
        gpio_out    = run_sel ? (team_out & mask_q) : '0;
        gpio_oeb    = run_sel ? (team_oeb | ~mask_q) : '1;
        designs_ncs = run_sel ? ~(NUM_TEAMS'(1) << (active_q - 8'd1)) : '1;
    end

    assign busy        = (state_q == ST_DRAIN);
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign unused_sink = ^{wbs_adr_i[1:0], mask_nxt};

endmodule

// File: tb/tb_gpio_team_mux.sv
// Bench for gpio_team_mux: Wishbone responses checked by a scoreboard monitor,
// pad routing and switch sequencing checked with directed expectations.
module tb_gpio_team_mux;

    localparam int NT = 4;
    localparam int NP = 38;

    logic           clk = 1'b0;
    logic           nrst;
    logic           stb, cyc, we;
    logic [3:0]     sel;
    logic [31:0]    dat_i, adr;
    logic           ack;
    logic [31:0]    dat_o;
    logic [NT*NP-1:0] d_out, d_oeb;
    logic [NP-1:0]  gpio_out, gpio_oeb;
    logic [NT-1:0]  ncs;
    logic           busy;

    logic [NP-1:0]  tout [4];
    logic [NP-1:0]  toeb [4];

    int             total = 0;
    int             bad = 0;
    logic [31:0]    exp_q [$];
    bit             watch_t1 = 1'b0;
    bit             t1_seen = 1'b0;

    always #5 clk = ~clk;

    assign d_out = {tout[3], tout[2], tout[1], tout[0]};
    assign d_oeb = {toeb[3], toeb[2], toeb[1], toeb[0]};

    gpio_team_mux dut (
        .wb_clk_i         (clk),
        .nrst             (nrst),
        .wbs_stb_i        (stb),
        .wbs_cyc_i        (cyc),
        .wbs_we_i         (we),
        .wbs_sel_i        (sel),
        .wbs_dat_i        (dat_i),
        .wbs_adr_i        (adr),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (dat_o),
        .designs_gpio_out (d_out),
        .designs_gpio_oeb (d_oeb),
        .gpio_out         (gpio_out),
        .gpio_oeb         (gpio_oeb),
        .designs_ncs      (ncs),
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // One single-cycle Wishbone request; returns just after the ack edge.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, input bit push);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb(1'b1, a, d, s, 32'h0, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        wb(1'b0, a, 32'h0, 4'hF, e, 1'b1);
    endtask

    task automatic chk_drain(input string name);
        for (int i = 0; i < 4; i++) begin
            chk({name, "_busy"}, 64'(busy), 64'd1);
            chk({name, "_ncs"}, 64'(ncs), 64'hF);
            chk({name, "_oeb"}, 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
            chk({name, "_out"}, 64'(gpio_out), 64'h0);
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst && ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_ack unexpected ack dat=%h", dat_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dat_o !== e) begin
                    bad++;
                    $display("FAIL wb_data got=%h want=%h", dat_o, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch_t1 && ncs[0] == 1'b0) t1_seen = 1'b1;
    end

    initial begin
        nrst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
        tout[0] = 38'h00_1111_1111; toeb[0] = 38'h3F_0000_0000;
        tout[1] = 38'h2A_1234_5678; toeb[1] = 38'h01_0F0F_00FF;
        tout[2] = 38'h15_CAFE_BABE; toeb[2] = 38'h00_F0F0_F0F0;
        tout[3] = 38'h3F_DEAD_BEEF; toeb[3] = 38'h2A_AAAA_AAAA;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", 64'(ncs), 64'hF);
        chk("rst_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_out", 64'(gpio_out), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        @(negedge clk) nrst = 1'b1;

        rd(32'h3000_000C, 32'h0000_0000);
        rd(32'h3000_0000, 32'h0000_0000);
        rd(32'h3000_0004, 32'hFFFF_FFFF);
        rd(32'h3000_0008, 32'h0000_003F);

        // Switch to team 2: four holdoff cycles then routed.
        wr(32'h3000_0000, 32'h2, 4'hF);
        chk_drain("commit");
        chk("commit_busy", 64'(busy), 64'h0);
        chk("commit_ncs", 64'(ncs), 64'hD);
        chk("commit_out", 64'(gpio_out), 64'(tout[1]));
        chk("commit_oeb", 64'(gpio_oeb), 64'(toeb[1]));
        rd(32'h3000_0000, 32'h0000_0002);
        rd(32'h3000_000C, 32'h0000_0200);

        // Ownership mask.
        tout[1] = '1; toeb[1] = '0;
        wr(32'h3000_0004, 32'h0000_00FF, 4'hF);
        wr(32'h3000_0008, 32'h0000_0000, 4'hF);
        chk("mask_out", 64'(gpio_out), 64'h00_0000_00FF);
        chk("mask_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FF00);
        rd(32'h3000_0004, 32'h0000_00FF);
        rd(32'h3000_0008, 32'h0000_0000);
        tout[1] = 38'h2A_1234_5678; toeb[1] = 38'h01_0F0F_00FF;

        // Illegal index, ERR clear, byte lanes, same-value write.
        wr(32'h3000_0000, 32'h5, 4'hF);
        chk("illegal_busy", 64'(busy), 64'h0);
        rd(32'h3000_0000, 32'h0000_0002);
        rd(32'h3000_000C, 32'h0000_0202);
        wr(32'h3000_000C, 32'h2, 4'hF);
        rd(32'h3000_000C, 32'h0000_0200);
        wr(32'h3000_0004, 32'hFFFF_FFFF, 4'h0);
        rd(32'h3000_0004, 32'h0000_00FF);
        wr(32'h3000_0000, 32'h1, 4'hE);
        chk("lane0_busy", 64'(busy), 64'h0);
        rd(32'h3000_0000, 32'h0000_0002);
        wr(32'h3000_0000, 32'h2, 4'h1);
        chk("same_busy", 64'(busy), 64'h0);
        wr(32'h3000_0004, 32'h0000_FF00, 4'h2);
        rd(32'h3000_0004, 32'h0000_FFFF);

        wr(32'h3000_0004, 32'hFFFF_FFFF, 4'hF);
        wr(32'h3000_0008, 32'h0000_003F, 4'hF);

        // Restarted switch: team 1 requested then superseded by team 3.
        watch_t1 = 1'b1;
        wr(32'h3000_0000, 32'h1, 4'hF);
        chk("restart_busy0", 64'(busy), 64'h1);
        wr(32'h3000_0000, 32'h3, 4'hF);
        chk_drain("restart");
        chk("restart_ncs", 64'(ncs), 64'hB);
        chk("restart_out", 64'(gpio_out), 64'(tout[2]));
        watch_t1 = 1'b0;
        chk("restart_no_t1", 64'(t1_seen), 64'h0);

        // Out-of-window request held for two cycles.
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("oow_ack", 64'(ack), 64'h0);
            chk("oow_dat", 64'(dat_o), 64'h0);
        end
        stb = 1'b0; cyc = 1'b0;

`ifdef GPIO_TEAM_MUX_LOCK_EN
        wr(32'h3000_000C, 32'h4, 4'hF);
        wr(32'h3000_0000, 32'h1, 4'hF);
        chk("lock_busy", 64'(busy), 64'h0);
        rd(32'h3000_0000, 32'h0000_0003);
        rd(32'h3000_000C, 32'h0000_0306);
        wr(32'h3000_0004, 32'h0, 4'hF);
        rd(32'h3000_0004, 32'hFFFF_FFFF);
`else
        wr(32'h3000_000C, 32'h4, 4'hF);
        rd(32'h3000_000C, 32'h0000_0300);
`endif

        // Asynchronous reset mid-cycle while an ack is high.
        wb(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("arst_ack", 64'(ack), 64'h0);
        chk("arst_ncs", 64'(ncs), 64'hF);
        chk("arst_oeb", 64'(gpio_oeb), 64'h3F_FFFF_FFFF);
        chk("arst_out", 64'(gpio_out), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        rd(32'h3000_000C, 32'h0000_0000);
        rd(32'h3000_0000, 32'h0000_0000);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
